// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if
//   Bundles the operand-side and result-side valid/ready handshakes of the
//   mac_accumulator lane.
//
//   Operand side (upstream -> block):
//     in_valid  operand beat valid
//     in_ready  block can accept a beat this cycle
//     in_act    signed activation, Q bits
//     in_wgt    signed weight, Q bits
//     in_last   beat is the final term of the current dot product
//   Result side (block -> downstream):
//     acc_valid acc_out/acc_ovf hold a result
//     acc_ready downstream accepts the result
//     acc_out   signed saturated dot product, DATA_WIDTH bits
//     acc_ovf   saturation occurred at least once in this vector
//
//   master: the environment driving operands and consuming results.
//   slave : the accumulator itself.
interface mac_accumulator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int Q          = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [Q-1:0]          in_act;
  logic [Q-1:0]          in_wgt;
  logic                  in_last;
  logic                  acc_valid;
  logic                  acc_ready;
  logic [DATA_WIDTH-1:0] acc_out;
  logic                  acc_ovf;

  modport master (
    output in_valid, in_act, in_wgt, in_last, acc_ready,
    input  in_ready, acc_valid, acc_out, acc_ovf
  );

  modport slave (
    input  in_valid, in_act, in_wgt, in_last, acc_ready,
    output in_ready, acc_valid, acc_out, acc_ovf
  );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Streaming signed multiply-accumulate engine for one neuron lane. Each
//   accepted beat contributes in_act * in_wgt (full 2*(Q-D_POINT) fractional
//   bit precision) to a running dot product. The beat flagged in_last closes
//   the vector: the saturated sum and a sticky overflow flag are presented on
//   a registered valid/ready output.
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  mac_accumulator_if.slave (operand and result handshakes)
//
//   Pipeline: stage 1 registers the exact product, stage 2 accumulates with
//   saturation. A pending result that downstream refuses freezes both stages
//   and drops in_ready in the same cycle.
module mac_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int Q          = 16,
  parameter int D_POINT    = 8
) (
  input  logic                clk,
  input  logic                rst,
  mac_accumulator_if.slave    bus
);

  // The product is exact only if the accumulator can hold all 2*Q bits;
  // D_POINT fixes the binary point and must lie within the operand.
  if (DATA_WIDTH < 2 * Q || D_POINT < 1 || D_POINT > Q) begin : g_param_check
    $error("mac_accumulator: illegal DATA_WIDTH/Q/D_POINT combination");
  end

  localparam logic [DATA_WIDTH-1:0] ACC_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                  adv;

  logic signed [2*Q-1:0] prod_full;
  logic [DATA_WIDTH-1:0] prod_ext;

  logic                  p_valid;
  logic                  p_last;
  logic [DATA_WIDTH-1:0] p_prod;

  logic [DATA_WIDTH-1:0] acc;
  logic                  first;
  logic                  sticky;

  logic                  acc_valid_q;
  logic [DATA_WIDTH-1:0] acc_out_q;
  logic                  acc_ovf_q;

  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH:0]   sum_wide;
  logic [DATA_WIDTH-1:0] sum_sat;
  logic                  ovf_now;
  logic                  ovf_vec;

  // The whole pipe moves unless a result is waiting on a stalled consumer.
  assign adv          = !(acc_valid_q && !bus.acc_ready);
  assign bus.in_ready = adv;

  assign bus.acc_valid = acc_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.acc_ovf   = acc_ovf_q;

  // Signed Q x Q product is exact in 2*Q bits; the size cast of a signed
  // value sign-extends it into the accumulator width.
  assign prod_full = $signed(bus.in_act) * $signed(bus.in_wgt);
  assign prod_ext  = DATA_WIDTH'(prod_full);

  // Stage 1: capture the product. p_last is captured even on bubbles; it is
  // only honoured when p_valid is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_prod  <= '0;
    end else if (adv) begin
      p_valid <= bus.in_valid;
      p_last  <= bus.in_last;
      p_prod  <= prod_ext;
    end
  end

  // Saturating add: one extra bit catches overflow, then clamp to the
  // representable range. A vector's first term starts from zero, so the
  // previous vector's accumulator and sticky flag never need clearing.
  always_comb begin
    base     = first ? '0 : acc;
    sum_wide = {base[DATA_WIDTH-1], base} + {p_prod[DATA_WIDTH-1], p_prod};
    ovf_now  = sum_wide[DATA_WIDTH] ^ sum_wide[DATA_WIDTH-1];
    sum_sat  = sum_wide[DATA_WIDTH-1:0];
    if (ovf_now) begin
      sum_sat = sum_wide[DATA_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    ovf_vec = (first ? 1'b0 : sticky) | ovf_now;
  end

  // Stage 2: accumulate, or publish on the last term. A result written in
  // the same cycle as the old one is consumed keeps acc_valid high, since
  // the later assignment wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      first       <= 1'b1;
      sticky      <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_out_q   <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      if (acc_valid_q && bus.acc_ready) begin
        acc_valid_q <= 1'b0;
      end
      if (adv && p_valid) begin
        if (p_last) begin
          acc_out_q   <= sum_sat;
          acc_ovf_q   <= ovf_vec;
          acc_valid_q <= 1'b1;
          first       <= 1'b1;
        end else begin
          acc    <= sum_sat;
          sticky <= ovf_vec;
          first  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator
//   Drives operand beats through mac_accumulator_if and scores every result
//   against an arithmetic dot-product model with per-term clamping. Expected
//   results are queued when the in_last beat is accepted; an independent
//   monitor pops and compares on each result handshake.
module tb_mac_accumulator;

  localparam int DW       = 32;
  localparam int QW       = 16;
  localparam int HS_LIMIT = 500;

  localparam longint ACC_MAX = (64'sd1 <<< 31) - 64'sd1;
  localparam longint ACC_MIN = -(64'sd1 <<< 31);

  typedef struct {
    logic [DW-1:0] val;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  mac_accumulator_if #(.DATA_WIDTH(DW), .Q(QW)) bus ();

  mac_accumulator #(.DATA_WIDTH(DW), .Q(QW), .D_POINT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t   sb[$];
  int     pop_cycles[$];
  int     total  = 0;
  int     passed = 0;
  int     cycle  = 0;
  longint model_acc = 0;
  bit     model_ovf = 1'b0;
  bit     ready_random = 1'b0;
  bit     ready_forced = 1'b1;

  // Clock and a free-running cycle counter for spacing checks.
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Sole driver of acc_ready, updated well clear of both clock edges.
  initial begin
    bus.acc_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.acc_ready = ready_random ? ($urandom_range(0, 3) != 0) : ready_forced;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: exact product, running sum clamped after every term.
  task automatic modelBeat(input logic [15:0] act, input logic [15:0] wgt, input logic last);
    longint s;
    s = model_acc + longint'($signed(act)) * longint'($signed(wgt));
    if (s > ACC_MAX) begin
      s = ACC_MAX;
      model_ovf = 1'b1;
    end else if (s < ACC_MIN) begin
      s = ACC_MIN;
      model_ovf = 1'b1;
    end
    if (last) begin
      sb.push_back('{val: 32'(s), ovf: model_ovf});
      model_acc = 0;
      model_ovf = 1'b0;
    end else begin
      model_acc = s;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic applyStimulus(input logic [15:0] act, input logic [15:0] wgt,
                               input logic last, input int bubbles);
    bit ok;
    int waited;
    for (int i = 0; i < bubbles; i++) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'($urandom_range(0, 1));
      bus.in_act   = 16'($urandom);
      bus.in_wgt   = 16'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_act   = act;
    bus.in_wgt   = wgt;
    bus.in_last  = last;
    ok     = 1'b0;
    waited = 0;
    while (!ok && waited < HS_LIMIT) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      waited++;
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (ok) begin
      modelBeat(act, wgt, last);
    end else begin
      total++;
      $display("[TB] FAIL handshake_timeout: in_ready stayed 0 for %0d cycles", HS_LIMIT);
    end
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    do begin
      @(posedge clk);
      w++;
    end while (sb.size() != 0 && w < HS_LIMIT);
    #1;
    if (sb.size() != 0) begin
      total++;
      $display("[TB] FAIL drain_timeout: %0d results never appeared", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: a result handshake happens at the coming edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.acc_valid && bus.acc_ready) begin
        pop_cycles.push_back(cycle);
        if (sb.size() == 0) begin
          total++;
          $display("[TB] FAIL unexpected_result: got 0x%08h, none expected", bus.acc_out);
        end else begin
          e = sb.pop_front();
          checkOutput("result_value", bus.acc_out, e.val);
          checkOutput("result_ovf", {31'b0, bus.acc_ovf}, {31'b0, e.ovf});
        end
      end
    end
  end

  initial begin
    int n;
    int len;
    logic [15:0] a;
    logic [15:0] w;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_act   = '0;
    bus.in_wgt   = '0;
    bus.in_last  = 1'b0;
    #3;
    checkOutput("reset_acc_valid", {31'b0, bus.acc_valid}, 32'd0);
    checkOutput("reset_acc_out", bus.acc_out, 32'd0);
    checkOutput("reset_acc_ovf", {31'b0, bus.acc_ovf}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    #19;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single-term vector and latency");
    applyStimulus(16'h0180, 16'h0200, 1'b1, 0);
    @(negedge clk);
    checkOutput("latency_stage1", {31'b0, bus.acc_valid}, 32'd0);
    @(negedge clk);
    checkOutput("latency_stage2", {31'b0, bus.acc_valid}, 32'd1);
    checkOutput("single_term_value", bus.acc_out, 32'h0003_0000);
    @(posedge clk);
    #1;
    waitDrain();

    $display("[TB] four-term vector, without and with bubbles");
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(16'h0100, 16'h0100, 1'b0, rep * $urandom_range(0, 3));
      applyStimulus(16'hFF00, 16'h0100, 1'b0, rep * $urandom_range(0, 3));
      applyStimulus(16'h0200, 16'h0100, 1'b0, rep * $urandom_range(0, 3));
      applyStimulus(16'h0080, 16'h0100, 1'b1, rep * $urandom_range(0, 3));
    end
    waitDrain();

    $display("[TB] positive and negative saturation");
    for (int i = 0; i < 3; i++) applyStimulus(16'h7FFF, 16'h7FFF, i == 2, 0);
    applyStimulus(16'h0100, 16'h0100, 1'b1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(16'h8000, 16'h7FFF, i == 2, 0);
    waitDrain();

    $display("[TB] backpressure");
    ready_forced = 1'b0;
    applyStimulus(16'h0100, 16'h0300, 1'b1, 0);
    applyStimulus(16'h0100, 16'hFD00, 1'b1, 0);
    fork
      applyStimulus(16'h0200, 16'h0200, 1'b1, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          checkOutput("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
          checkOutput("bp_valid_held", {31'b0, bus.acc_valid}, 32'd1);
          checkOutput("bp_out_held", bus.acc_out, 32'h0003_0000);
        end
        ready_forced = 1'b1;
      end
    join
    waitDrain();
    n = pop_cycles.size();
    checkOutput("bp_consecutive_ab", 32'(pop_cycles[n-2] - pop_cycles[n-3]), 32'd1);
    checkOutput("bp_consecutive_bc", 32'(pop_cycles[n-1] - pop_cycles[n-2]), 32'd1);

    $display("[TB] randomized vectors with random backpressure");
    ready_random = 1'b1;
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        a = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000) : 16'($urandom);
        w = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000) : 16'($urandom);
        applyStimulus(a, w, k == len - 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
    end
    ready_random = 1'b0;
    waitDrain();

    $display("[TB] reset mid-vector");
    applyStimulus(16'h0300, 16'h0500, 1'b0, 0);
    applyStimulus(16'h0700, 16'h0100, 1'b0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_acc = 0;
    model_ovf = 1'b0;
    #1;
    checkOutput("midrst_acc_valid", {31'b0, bus.acc_valid}, 32'd0);
    checkOutput("midrst_acc_out", bus.acc_out, 32'd0);
    checkOutput("midrst_acc_ovf", {31'b0, bus.acc_ovf}, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(16'h0100, 16'h0100, 1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("post_reset_value", bus.acc_out, 32'h0001_0000);
    @(posedge clk);
    #1;
    waitDrain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
